// File: rtl/fifo_flag_ctrl_pkg.sv
// Shared definitions for the FIFO flag controller: default address width
// and the occupancy state encodings.
package fifo_flag_ctrl_pkg;

    localparam int A_LENGTH_DEF = 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_PART  = 2'b01,
        S_FULL  = 2'b10
    } fifo_state_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping binary pointer for the FIFO RAM: advances by one on inc,
// synchronous clear has priority over inc.
module fifo_ptr_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Natural overflow of the WIDTH-bit add gives the DEPTH-1 -> 0 wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fifo_flag_ctrl.sv
// Pointer and flag controller for the single-clock FIFO: grants requests,
// tracks occupancy, and produces registered status flags and sticky errors.
module fifo_flag_ctrl
    import fifo_flag_ctrl_pkg::*;
#(
    parameter int A_LENGTH = A_LENGTH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [A_LENGTH:0]   af_thresh,
    input  logic [A_LENGTH:0]   ae_thresh,
    input  logic                clr_err,
    output logic                wr_ack,
    output logic                rd_ack,
    output logic [A_LENGTH-1:0] wr_addr,
    output logic [A_LENGTH-1:0] rd_addr,
    output logic [A_LENGTH:0]   count,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic                overflow,
    output logic                underflow
);

    localparam int CW = A_LENGTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** A_LENGTH);

    fifo_state_t      state;
    fifo_state_t      state_next;
    logic [CW-1:0]    count_next;

    // Grants depend only on registered flags, so rd_en never reaches wr_ack.
    assign wr_ack = wr_en & ~full & ~flush;
    assign rd_ack = rd_en & ~empty & ~flush;

    fifo_ptr_cnt #(.WIDTH(A_LENGTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (wr_ack),
        .ptr     (wr_addr)
    );

    fifo_ptr_cnt #(.WIDTH(A_LENGTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .inc     (rd_ack),
        .ptr     (rd_addr)
    );

    always_comb begin
        count_next = count;
        state_next = state;
        if (flush) begin
            count_next = '0;
            state_next = S_EMPTY;
        end else begin
            count_next = count + {{(CW-1){1'b0}}, wr_ack} - {{(CW-1){1'b0}}, rd_ack};
            case (state)
                S_EMPTY: if (count_next != '0) state_next = S_PART;
                S_PART: begin
                    if (count_next == DEPTH) begin
                        state_next = S_FULL;
                    end else if (count_next == '0) begin
                        state_next = S_EMPTY;
                    end
                end
                S_FULL:  if (count_next != DEPTH) state_next = S_PART;
                default: state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            state        <= S_EMPTY;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else if (flush) begin
            count        <= '0;
            state        <= S_EMPTY;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            count        <= count_next;
            state        <= state_next;
            empty        <= (state_next == S_EMPTY);
            full         <= (state_next == S_FULL);
            almost_empty <= (count_next <= ae_thresh);
            almost_full  <= (count_next >= af_thresh);
        end
    end

    // Errors are kept across a flush; a new error beats clr_err in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
